// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D memory arbiter: FSM state encoding, grant
// side constants and the round-robin pick used when leaving IDLE.
package mem_arb_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  // Pick the side to serve. A lone requester always wins; on a tie the
  // side that was not served last wins, so neither cache can starve.
  function automatic logic pick_grant(input logic i_req,
                                      input logic d_req,
                                      input logic last_grant);
    logic g;
    if (i_req && d_req) begin
      g = ~last_grant;
    end else if (d_req) begin
      g = GRANT_D;
    end else begin
      g = GRANT_I;
    end
    return g;
  endfunction

endpackage

// File: rtl/decoder2.sv
// 1-of-2 decoder with enable; routes a single completion pulse to the
// output selected by sel (bit 0 for sel=0, bit 1 for sel=1).
module decoder2 (
  input  logic       sel,
  input  logic       enable,
  output logic [1:0] out
);

  // Decode sel into a one-hot pair, all zero when not enabled.
  always_comb begin
    out = 2'b00;
    if (enable) begin
      out[sel] = 1'b1;
    end else begin
      out = 2'b00;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one physical memory port between the I-cache and
// D-cache miss paths. A granted transaction is latched in full, so the
// requester inputs are ignored until memory answers; the completion is
// steered back to the winner only.
module mem_arbiter
  import mem_arb_types::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_t            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

  logic                  i_req;
  logic                  d_req;
  logic                  grant;
  logic                  resp_en;
  logic [1:0]            resp_vec;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // Next-state, grant selection and transaction latching.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    grant        = pick_grant(i_req, d_req, last_grant_q);
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          last_grant_d = grant;
          if (grant == GRANT_D) begin
            state_d = BUSY_D;
            addr_d  = d_address;
            wdata_d = d_wdata;
            // read+write together is illegal; the write takes priority
            wr_d    = d_write;
            rd_d    = ~d_write;
          end else begin
            state_d = BUSY_I;
            addr_d  = i_address;
            wdata_d = {LINE_WIDTH{1'b0}};
            wr_d    = 1'b0;
            rd_d    = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (pmem_resp) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  // State and latched-transaction registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= {ADDR_WIDTH{1'b0}};
      wdata_q      <= {LINE_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // While busy, last_grant_q names the side being served.
  assign resp_en = (state_q != IDLE) & pmem_resp;

  decoder2 u_resp_dec (
    .sel    (last_grant_q),
    .enable (resp_en),
    .out    (resp_vec)
  );

  assign i_resp       = resp_vec[0];
  assign d_resp       = resp_vec[1];
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;
  assign pmem_read    = rd_q;
  assign pmem_write   = wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by
// randomized traffic checked against a transaction-level model
// (pending flags plus "who was served last").
module tb_mem_arbiter;

  logic         clk;
  logic         rst;
  logic         i_read;
  logic [15:0]  i_address;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int n_cmp = 0;
  int n_bad = 0;

  // model: pending requests, their parameters and the last side served
  bit           pend_i, pend_d;
  bit           d_rd_v, d_wr_v;
  logic [15:0]  i_addr_v, d_addr_v;
  logic [127:0] d_wdata_v;
  bit           last_win;

  mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_pins();
    i_read    = pend_i;
    d_read    = pend_d & d_rd_v;
    d_write   = pend_d & d_wr_v;
    i_address = i_addr_v;
    d_address = d_addr_v;
    d_wdata   = d_wdata_v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pend_i = 1'b0;
    pend_d = 1'b0;
    pmem_resp = 1'b0;
    drive_pins();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_win = 1'b1;
  endtask

  // One IDLE cycle: present the model's requests; nothing may be active.
  task automatic idle_cycle(input bit spur);
    @(negedge clk);
    drive_pins();
    pmem_resp  = spur;
    pmem_rdata = rand128();
    #1;
    chk("idle_pmem_read", pmem_read, 1'b0);
    chk("idle_pmem_write", pmem_write, 1'b0);
    chk("idle_i_resp", i_resp, 1'b0);
    chk("idle_d_resp", d_resp, 1'b0);
  endtask

  // A granted transaction. mode 0: inputs untouched; 1: I address moved
  // to FFF0 and request dropped in cycle 2; 2: random winner disturbance.
  task automatic run_txn(input int lat, input int mode, input bit fixed_rd,
                         input logic [127:0] rd_pat);
    bit           win;
    bit           exp_wr;
    logic [15:0]  exp_addr;
    logic [127:0] exp_wd;
    logic [127:0] rd;
    bit           last;
    if (pend_i && pend_d) win = ~last_win;
    else if (pend_d)      win = 1'b1;
    else                  win = 1'b0;
    exp_wr   = win && d_wr_v;
    exp_addr = win ? d_addr_v : i_addr_v;
    exp_wd   = d_wdata_v;
    last_win = win;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      last = (k == lat);
      if (mode == 1 && k == 2) begin
        i_address = 16'hFFF0;
        i_read    = 1'b0;
      end else if (mode == 2) begin
        if ($urandom_range(0, 2) == 0) begin
          if (win) d_address = 16'($urandom);
          else     i_address = 16'($urandom);
        end
        if ($urandom_range(0, 3) == 0) begin
          if (win) begin
            d_read  = 1'b0;
            d_write = 1'b0;
          end else begin
            i_read = 1'b0;
          end
        end
      end
      rd         = fixed_rd ? rd_pat : rand128();
      pmem_rdata = rd;
      pmem_resp  = last;
      #1;
      chk("busy_pmem_read", pmem_read, !exp_wr);
      chk("busy_pmem_write", pmem_write, exp_wr);
      chk("busy_pmem_address", pmem_address, exp_addr);
      if (exp_wr) chk("busy_pmem_wdata", pmem_wdata, exp_wd);
      chk("busy_i_resp", i_resp, last && !win);
      chk("busy_d_resp", d_resp, last && win);
      if (last) begin
        if (win) chk("d_rdata", d_rdata, rd);
        else     chk("i_rdata", i_rdata, rd);
      end
    end
    if (win) pend_d = 1'b0;
    else     pend_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pend_i = 1'b0; pend_d = 1'b0;
    d_rd_v = 1'b0; d_wr_v = 1'b0;
    i_addr_v = 16'h0000; d_addr_v = 16'h0000;
    d_wdata_v = 128'h0;
    last_win = 1'b1;
    pmem_resp = 1'b0;
    pmem_rdata = 128'h0;
    drive_pins();

    // reset: all outputs zero for 3 idle cycles
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("rst_pmem_read", pmem_read, 1'b0);
      chk("rst_pmem_write", pmem_write, 1'b0);
      chk("rst_pmem_address", pmem_address, 16'h0000);
      chk("rst_pmem_wdata", pmem_wdata, 128'h0);
      chk("rst_i_resp", i_resp, 1'b0);
      chk("rst_d_resp", d_resp, 1'b0);
      chk("rst_i_rdata", i_rdata, 128'h0);
      chk("rst_d_rdata", d_rdata, 128'h0);
    end

    // single I read, 4-cycle memory latency
    pend_i = 1'b1; i_addr_v = 16'h1230;
    idle_cycle(1'b0);
    run_txn(4, 0, 1'b1, {16{8'hA5}});

    // single D write
    pend_d = 1'b1; d_rd_v = 1'b0; d_wr_v = 1'b1;
    d_addr_v = 16'h4440; d_wdata_v = 128'h0123456789ABCDEF_FEDCBA9876543210;
    idle_cycle(1'b0);
    run_txn(3, 0, 1'b0, 128'h0);

    // simultaneous requests out of reset: I, D, then I again
    do_reset();
    pend_i = 1'b1; i_addr_v = 16'h1000;
    pend_d = 1'b1; d_rd_v = 1'b1; d_wr_v = 1'b0; d_addr_v = 16'h2000;
    idle_cycle(1'b0);
    run_txn(2, 0, 1'b0, 128'h0);
    idle_cycle(1'b1);
    run_txn(2, 0, 1'b0, 128'h0);
    idle_cycle(1'b0);
    pend_i = 1'b1; i_addr_v = 16'h3000;
    pend_d = 1'b1; d_addr_v = 16'h5000;
    idle_cycle(1'b0);
    run_txn(1, 0, 1'b0, 128'h0);
    idle_cycle(1'b0);
    run_txn(1, 0, 1'b0, 128'h0);

    // mid-transaction address change and request drop are ignored
    pend_i = 1'b1; i_addr_v = 16'h7770;
    idle_cycle(1'b0);
    run_txn(4, 1, 1'b0, 128'h0);

    // reset in BUSY_D, then a spurious memory response while idle
    pend_d = 1'b1; d_rd_v = 1'b0; d_wr_v = 1'b1; d_addr_v = 16'h6660;
    d_wdata_v = rand128();
    idle_cycle(1'b0);
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    chk("rstbusy_pre_write", pmem_write, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    pend_i = 1'b0; pend_d = 1'b0;
    drive_pins();
    @(negedge clk);
    rst = 1'b0;
    last_win = 1'b1;
    #1;
    chk("rstbusy_pmem_read", pmem_read, 1'b0);
    chk("rstbusy_pmem_write", pmem_write, 1'b0);
    chk("rstbusy_i_resp", i_resp, 1'b0);
    chk("rstbusy_d_resp", d_resp, 1'b0);
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    chk("spur_i_resp", i_resp, 1'b0);
    chk("spur_d_resp", d_resp, 1'b0);
    chk("spur_pmem_read", pmem_read, 1'b0);
    chk("spur_pmem_write", pmem_write, 1'b0);

    // randomized traffic
    for (int it = 0; it < 300; it++) begin
      if (!pend_i && $urandom_range(0, 1) == 1) begin
        pend_i   = 1'b1;
        i_addr_v = {12'($urandom), 4'h0};
      end
      if (!pend_d && $urandom_range(0, 1) == 1) begin
        int r;
        r = $urandom_range(0, 9);
        pend_d    = 1'b1;
        d_rd_v    = (r < 5);
        d_wr_v    = (r == 0) || (r >= 5);
        d_addr_v  = {12'($urandom), 4'h0};
        d_wdata_v = rand128();
      end
      idle_cycle($urandom_range(0, 3) == 0);
      if (pend_i || pend_d) begin
        run_txn($urandom_range(1, 5), ($urandom_range(0, 1) == 1) ? 2 : 0, 1'b0, 128'h0);
      end
    end

    pend_i = 1'b0; pend_d = 1'b0;
    idle_cycle(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
